// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback-source round-robin arbiter.
package wb_arb_pkg;

    localparam int unsigned N_REQ         = 6;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned SEL_W         = 3;
    localparam int unsigned BURST_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF   = 15;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Mux select per requester: ALU, MEM, IMM, PC+1, IO, SHIFT
    localparam logic [SEL_W-1:0] SEL_CODE [0:N_REQ-1] = '{
        3'b000, 3'b010, 3'b001, 3'b011, 3'b111, 3'b110
    };

    function automatic logic [SEL_W-1:0] sel_of(input logic [IDX_W-1:0] idx);
        logic [SEL_W-1:0] code;
        code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                code = SEL_CODE[i];
            end
        end
        return code;
    endfunction

    // A counter that only ever reaches max_val-1 needs this many bits.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin picker: first eligible requester after 'last'.
module rr_pick6
    import wb_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic [N_REQ-1:0] excl,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam int unsigned POS_W = IDX_W + 1;

    logic [N_REQ-1:0] elig;
    logic [IDX_W-1:0] start;
    logic [POS_W-1:0] pos;

    // Walk the rotated order start..start+5 (mod 6); first hit wins.
    always_comb begin
        elig  = req & ~excl;
        start = (last >= IDX_W'(N_REQ - 1)) ? '0 : last + IDX_W'(1);
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = POS_W'(start) + POS_W'(k);
            if (pos >= POS_W'(N_REQ)) begin
                pos = pos - POS_W'(N_REQ);
            end
            if (!found && elig[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_src_arbiter.sv
// Round-robin arbiter for the six-source writeback mux with burst limit and
// stall-timeout abort.
module wb_src_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             ready,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic [IDX_W-1:0] owner,
    output logic             valid,
    output logic             beat,
    output logic             timeout_err
);

    localparam int unsigned BEAT_W  = cnt_width(BURST_MAX);
    localparam int unsigned STALL_W = cnt_width(TIMEOUT);
    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_MAX - 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);

    arb_state_e         state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               valid_q, valid_d;
    logic               terr_q, terr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    logic               beat_c;
    logic               rel_req, rel_beat, rel_tmo;
    logic               release_c, abort_c;
    logic [IDX_W-1:0]   pick_last;
    logic [N_REQ-1:0]   pick_excl;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;

    // Release detection and picker inputs; a timed-out owner sits out one round.
    always_comb begin
        beat_c    = valid_q & ready;
        rel_req   = !req[owner_q];
        rel_beat  = beat_c && (beat_cnt_q == BEAT_LAST);
        rel_tmo   = valid_q && !ready && (stall_cnt_q == STALL_LAST);
        release_c = (state_q == BUSY) && (rel_req || rel_beat || rel_tmo);
        abort_c   = (state_q == BUSY) && rel_tmo && !rel_beat;
        pick_last = (state_q == BUSY) ? owner_q : last_q;
        pick_excl = abort_c ? (N_REQ'(1) << owner_q) : '0;
    end

    rr_pick6 u_pick (
        .req   (req),
        .last  (pick_last),
        .excl  (pick_excl),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Next-state: grant on the same edge as release so grants run back to back.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        sel_d       = sel_q;
        owner_d     = owner_q;
        last_d      = last_q;
        valid_d     = valid_q;
        terr_d      = 1'b0;
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    sel_d   = sel_of(pick_idx);
                    owner_d = pick_idx;
                    valid_d = 1'b1;
                end
            end
            BUSY: begin
                if (release_c) begin
                    last_d      = owner_q;
                    beat_cnt_d  = '0;
                    stall_cnt_d = '0;
                    terr_d      = abort_c;
                    if (pick_found) begin
                        gnt_d   = N_REQ'(1) << pick_idx;
                        sel_d   = sel_of(pick_idx);
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        sel_d   = '0;
                        valid_d = 1'b0;
                    end
                end else if (beat_c) begin
                    beat_cnt_d  = beat_cnt_q + BEAT_W'(1);
                    stall_cnt_d = '0;
                end else if (!ready) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            sel_q       <= '0;
            owner_q     <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            valid_q     <= 1'b0;
            terr_q      <= 1'b0;
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            terr_q      <= terr_d;
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign gnt         = gnt_q;
    assign sel         = sel_q;
    assign owner       = owner_q;
    assign valid       = valid_q;
    assign beat        = beat_c;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_wb_src_arbiter.sv
// Self-checking bench for wb_src_arbiter: vector table plus hand-written
// glitch and async-reset sequences, checked through an expectation queue.
module tb_wb_src_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] req;
    logic       ready;
    logic [5:0] gnt;
    logic [2:0] sel;
    logic [2:0] owner;
    logic       valid;
    logic       beat;
    logic       timeout_err;

    wb_src_arbiter #(.BURST_MAX(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ready       (ready),
        .gnt         (gnt),
        .sel         (sel),
        .owner       (owner),
        .valid       (valid),
        .beat        (beat),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs for one cycle and the outputs expected during that same cycle.
    typedef struct packed {
        logic [5:0] req;
        logic       ready;
        logic [5:0] gnt;
        logic [2:0] sel;
        logic [2:0] owner;
        logic       own_chk;
        logic       valid;
        logic       beat;
        logic       terr;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [2:0] code_of(input int i);
        case (i)
            0: return 3'b000;
            1: return 3'b010;
            2: return 3'b001;
            3: return 3'b011;
            4: return 3'b111;
            5: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic vec_t busy_v(input logic [5:0] r, input logic rd, input int i, input logic t);
        vec_t v;
        v.req = r; v.ready = rd;
        v.gnt = 6'(1) << i; v.sel = code_of(i); v.owner = 3'(i); v.own_chk = 1'b1;
        v.valid = 1'b1; v.beat = rd; v.terr = t;
        return v;
    endfunction

    function automatic vec_t idle_v(input logic [5:0] r, input logic rd, input logic t);
        vec_t v;
        v.req = r; v.ready = rd;
        v.gnt = '0; v.sel = '0; v.owner = '0; v.own_chk = 1'b0;
        v.valid = 1'b0; v.beat = 1'b0; v.terr = t;
        return v;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [2:0] ao, eo;
        ao = e.own_chk ? owner : 3'd0;
        eo = e.own_chk ? e.owner : 3'd0;
        total++;
        if ({gnt, sel, ao, valid, beat, timeout_err} !== {e.gnt, e.sel, eo, e.valid, e.beat, e.terr}) begin
            bad++;
            $display("FAIL %s: got gnt=%b sel=%b owner=%0d valid=%b beat=%b terr=%b, want gnt=%b sel=%b owner=%0d valid=%b beat=%b terr=%b",
                     name, gnt, sel, ao, valid, beat, timeout_err,
                     e.gnt, e.sel, eo, e.valid, e.beat, e.terr);
        end
    endtask

    task automatic expect_now(input string name, input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        e = exp_q.pop_front();
        check(name, e);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        vec_t e;
        exp_q.push_back(v);
        @(negedge clk);
        req   = v.req;
        ready = v.ready;
        #1;
        e = exp_q.pop_front();
        check(name, e);
    endtask

    task automatic build_table();
        // Full rotation 0..5,0 with 4 beats each and no gaps.
        for (int g = 0; g < 7; g++)
            for (int b = 0; b < 4; b++)
                vecs.push_back(busy_v(6'h3F, 1'b1, g % 6, 1'b0));
        // Only requester 2: owner 1 beats once then drops, 2 keeps the path.
        vecs.push_back(busy_v(6'h04, 1'b1, 1, 1'b0));
        for (int k = 0; k < 12; k++)
            vecs.push_back(busy_v(6'h04, 1'b1, 2, 1'b0));
        // Owner 3 drops after 2 beats with 5 waiting; 5 then gets a full burst.
        vecs.push_back(busy_v(6'h08, 1'b1, 2, 1'b0));
        vecs.push_back(busy_v(6'h28, 1'b1, 3, 1'b0));
        vecs.push_back(busy_v(6'h28, 1'b1, 3, 1'b0));
        vecs.push_back(busy_v(6'h20, 1'b0, 3, 1'b0));
        for (int k = 0; k < 4; k++)
            vecs.push_back(busy_v(6'h21, 1'b1, 5, 1'b0));
        // Owner 4 stalls 15 cycles with requester 0 waiting.
        vecs.push_back(busy_v(6'h10, 1'b1, 0, 1'b0));
        for (int k = 0; k < 15; k++)
            vecs.push_back(busy_v(6'h11, 1'b0, 4, 1'b0));
        vecs.push_back(busy_v(6'h01, 1'b1, 0, 1'b1));
        // Owner 4 stalls 15 cycles alone: abort leads to IDLE, then regrant.
        vecs.push_back(busy_v(6'h10, 1'b1, 0, 1'b0));
        for (int k = 0; k < 15; k++)
            vecs.push_back(busy_v(6'h10, 1'b0, 4, 1'b0));
        vecs.push_back(idle_v(6'h10, 1'b1, 1'b1));
        vecs.push_back(busy_v(6'h00, 1'b1, 4, 1'b0));
        vecs.push_back(idle_v(6'h00, 1'b1, 1'b0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: sim time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        rst_n = 1'b0;
        req   = 6'h3F;
        ready = 1'b1;
        build_table();

        @(negedge clk);
        #1;
        rv = idle_v(6'h3F, 1'b1, 1'b0);
        rv.own_chk = 1'b1;
        expect_now("reset", rv);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // Request pulse that never meets a clock edge must not be granted.
        @(negedge clk);
        #1 req = 6'h04;
        #3 req = 6'h00;
        run_vec("idle_glitch", idle_v(6'h00, 1'b1, 1'b0));

        // Async reset in the middle of owner 5's burst.
        run_vec("burst_pre", idle_v(6'h3F, 1'b1, 1'b0));
        run_vec("burst_b0", busy_v(6'h3F, 1'b1, 5, 1'b0));
        run_vec("burst_b1", busy_v(6'h3F, 1'b1, 5, 1'b0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        rv = idle_v(6'h3F, 1'b1, 1'b0);
        rv.own_chk = 1'b1;
        expect_now("async_rst", rv);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("rst_restart", busy_v(6'h3F, 1'b1, 0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
